// File: rtl/if_bus_bridge_pkg.sv
// Shared definitions for the instruction-fetch bus bridge: bus widths, reset level,
// FSM encodings, NOP constant and the fetch-error active level.
package if_bus_bridge_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam logic        RST_ACTIVE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN      = 32'h0000_0000;
  localparam logic        FETCH_ERR_ON  = 1'b1;
  localparam logic        FETCH_ERR_OFF = 1'b0;
  localparam int unsigned TIMER_W       = 8;

endpackage

// File: rtl/if_bus_bridge.sv
// Instruction-fetch bridge: holds one fetched word, stalls the pipeline on a miss and
// fetches over a req/ack memory bus; faulted fetches return a NOP and pulse fetch_err_o.
module if_bus_bridge
  import if_bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = BUS_ADDR_W,
  parameter int unsigned DATA_W  = BUS_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stall_req_o,
  output logic              fetch_err_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_err_i
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0]  NOP_WORD   = DATA_W'(NOP_INSN);

  fetch_state_e        state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   held_addr_q, held_addr_d;
  logic [DATA_W-1:0]   held_data_q, held_data_d;
  logic                bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                fetch_err_q, fetch_err_d;
  logic                hit_s;
  logic                busy_exit_s;

  assign hit_s       = cpu_ce_i & valid_q & (cpu_addr_i == held_addr_q);
  assign cpu_data_o  = hit_s ? held_data_q : NOP_WORD;
  assign stall_req_o = cpu_ce_i & ~hit_s;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign fetch_err_o = fetch_err_q;

  // Next-state logic for the fetch FSM, timer and held entry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    valid_d     = valid_q;
    held_addr_d = held_addr_q;
    held_data_d = held_data_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    fetch_err_d = FETCH_ERR_OFF;
    busy_exit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_ce_i && !hit_s) begin
          if (cpu_addr_i[1:0] == 2'b00) begin
            bus_addr_d = cpu_addr_i;
            bus_req_d  = 1'b1;
            timer_d    = {TIMER_W{1'b0}};
            state_d    = ST_BUSY;
          end else begin
            // Misaligned PC: complete locally with a NOP, no bus traffic.
            held_addr_d = cpu_addr_i;
            held_data_d = NOP_WORD;
            valid_d     = 1'b1;
            fetch_err_d = FETCH_ERR_ON;
          end
        end else begin
          bus_req_d = 1'b0;
        end
      end
      ST_BUSY: begin
        timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
        if (bus_err_i) begin
          held_data_d = NOP_WORD;
          fetch_err_d = FETCH_ERR_ON;
          busy_exit_s = 1'b1;
        end else if (bus_ack_i) begin
          held_data_d = bus_data_i;
          busy_exit_s = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          held_data_d = NOP_WORD;
          fetch_err_d = FETCH_ERR_ON;
          busy_exit_s = 1'b1;
        end else begin
          busy_exit_s = 1'b0;
        end
        if (busy_exit_s) begin
          held_addr_d = bus_addr_q;
          valid_d     = 1'b1;
          bus_req_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_IDLE;
      timer_q     <= {TIMER_W{1'b0}};
      valid_q     <= 1'b0;
      held_addr_q <= {ADDR_W{1'b0}};
      held_data_q <= {DATA_W{1'b0}};
      bus_req_q   <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      fetch_err_q <= FETCH_ERR_OFF;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      held_addr_q <= held_addr_d;
      held_data_q <= held_data_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

endmodule

// File: tb/tb_if_bus_bridge.sv
// Directed self-checking bench for if_bus_bridge: fetch latency, hits, timeout,
// error priority, misaligned fetch and reset during an outstanding request.
module tb_if_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stall_req_o;
  logic        fetch_err_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic        bus_err_i;

  int n_assert = 0;
  int n_fail   = 0;
  int req_cnt;
  int guard;

  if_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_o (cpu_data_o),
    .stall_req_o(stall_req_o),
    .fetch_err_o(fetch_err_o),
    .bus_req_o  (bus_req_o),
    .bus_addr_o (bus_addr_o),
    .bus_ack_i  (bus_ack_i),
    .bus_data_i (bus_data_i),
    .bus_err_i  (bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then set and
  // outputs checked 1 time unit later, well away from either edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = 32'h0;
    bus_ack_i = 1'b0; bus_data_i = 32'h0; bus_err_i = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err_o}, 32'd0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    chk("rst_stall", {31'b0, stall_req_o}, 32'd0);

    // Basic fetch of 0x0, ack on the third request cycle -> 4 stall cycles.
    cyc(); rst = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h0; #1;
    chk("bf_stall_n", {31'b0, stall_req_o}, 32'd1);
    chk("bf_req_n", {31'b0, bus_req_o}, 32'd0);
    cyc(); #1;
    chk("bf_req_n1", {31'b0, bus_req_o}, 32'd1);
    chk("bf_addr_n1", bus_addr_o, 32'h0);
    chk("bf_stall_n1", {31'b0, stall_req_o}, 32'd1);
    cyc(); #1;
    chk("bf_stall_n2", {31'b0, stall_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b1; bus_data_i = 32'h3401_1100; #1;
    chk("bf_stall_n3", {31'b0, stall_req_o}, 32'd1);
    chk("bf_req_n3", {31'b0, bus_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b0; bus_data_i = 32'h0; #1;
    chk("bf_stall_n4", {31'b0, stall_req_o}, 32'd0);
    chk("bf_data_n4", cpu_data_o, 32'h3401_1100);
    chk("bf_req_n4", {31'b0, bus_req_o}, 32'd0);
    chk("bf_err_n4", {31'b0, fetch_err_o}, 32'd0);

    // cpu_ce_i low: no output, no stall.
    cyc(); cpu_ce_i = 1'b0; #1;
    chk("ce0_data", cpu_data_o, 32'h0);
    chk("ce0_stall", {31'b0, stall_req_o}, 32'd0);

    // Fetch 0x4 with a one-cycle ack, then hold it for 5 hit cycles.
    cyc(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h4; #1;
    chk("sq_stall_m", {31'b0, stall_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b1; bus_data_i = 32'h2008_0005; #1;
    chk("sq_addr_m1", bus_addr_o, 32'h4);
    chk("sq_stall_m1", {31'b0, stall_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b0; bus_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sq_hit_stall", {31'b0, stall_req_o}, 32'd0);
      chk("sq_hit_req", {31'b0, bus_req_o}, 32'd0);
      chk("sq_hit_data", cpu_data_o, 32'h2008_0005);
      cyc();
    end
    // Move to 0x8 and never ack: timeout after exactly 16 request cycles.
    cpu_addr_i = 32'h8; #1;
    chk("to_stall", {31'b0, stall_req_o}, 32'd1);
    cyc(); #1;
    chk("to_addr", bus_addr_o, 32'h8);
    req_cnt = 0;
    guard   = 0;
    while (bus_req_o && guard < 40) begin
      chk("to_stall_busy", {31'b0, stall_req_o}, 32'd1);
      chk("to_err_busy", {31'b0, fetch_err_o}, 32'd0);
      req_cnt++;
      guard++;
      cyc(); #1;
    end
    chk("to_req_cycles", req_cnt, 32'd16);
    chk("to_err_pulse", {31'b0, fetch_err_o}, 32'd1);
    chk("to_data_nop", cpu_data_o, 32'h0);
    chk("to_stall_rel", {31'b0, stall_req_o}, 32'd0);
    cyc(); #1;
    chk("to_err_end", {31'b0, fetch_err_o}, 32'd0);
    chk("to_no_req", {31'b0, bus_req_o}, 32'd0);

    // Simultaneous error and ack: error wins.
    cyc(); cpu_addr_i = 32'hC; #1;
    chk("ea_stall", {31'b0, stall_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_data_i = 32'hFFFF_FFFF; #1;
    chk("ea_req", {31'b0, bus_req_o}, 32'd1);
    cyc(); bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_data_i = 32'h0; #1;
    chk("ea_req_off", {31'b0, bus_req_o}, 32'd0);
    chk("ea_err", {31'b0, fetch_err_o}, 32'd1);
    chk("ea_data", cpu_data_o, 32'h0);
    chk("ea_stall_rel", {31'b0, stall_req_o}, 32'd0);

    // Misaligned 0x6: no bus request, error pulse next cycle.
    cyc(); cpu_addr_i = 32'h6; #1;
    chk("ma_stall", {31'b0, stall_req_o}, 32'd1);
    chk("ma_req_n", {31'b0, bus_req_o}, 32'd0);
    cyc(); #1;
    chk("ma_req_n1", {31'b0, bus_req_o}, 32'd0);
    chk("ma_err", {31'b0, fetch_err_o}, 32'd1);
    chk("ma_data", cpu_data_o, 32'h0);
    chk("ma_stall_rel", {31'b0, stall_req_o}, 32'd0);
    cyc(); #1;
    chk("ma_err_end", {31'b0, fetch_err_o}, 32'd0);

    // Reset during BUSY, late ack ignored, address refetched.
    cyc(); cpu_addr_i = 32'h10; #1;
    chk("rb_stall", {31'b0, stall_req_o}, 32'd1);
    cyc(); rst = 1'b1; #1;
    chk("rb_req", {31'b0, bus_req_o}, 32'd1);
    cyc(); rst = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111; #1;
    chk("rb_req_off", {31'b0, bus_req_o}, 32'd0);
    chk("rb_stall_inv", {31'b0, stall_req_o}, 32'd1);
    chk("rb_data_inv", cpu_data_o, 32'h0);
    cyc(); bus_ack_i = 1'b0; bus_data_i = 32'h0; #1;
    chk("rb_ack_ignored", {31'b0, stall_req_o}, 32'd1);
    chk("rb_refetch_req", {31'b0, bus_req_o}, 32'd1);
    chk("rb_refetch_addr", bus_addr_o, 32'h10);
    bus_ack_i = 1'b1; bus_data_i = 32'h2222_2222;
    cyc(); bus_ack_i = 1'b0; bus_data_i = 32'h0; #1;
    chk("rb_data", cpu_data_o, 32'h2222_2222);
    chk("rb_stall_rel", {31'b0, stall_req_o}, 32'd0);
    chk("rb_err", {31'b0, fetch_err_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
